cdc_fifo_rd_ctrl: RTL and testbench

Read-side controller for the clock-domain-crossing FIFO in the LVDS 7:1 receive path. It runs entirely in the read clock domain. It synchronises the write pointer, drives the read address of the dual-clock FIFO RAM, and returns the Gray-coded read pointer to the write domain. Read data is presented to the downstream pixel/word logic on a first-word-fall-through valid/ready interface.

---
 rtl/cdc_fifo_rd_ctrl_pkg.sv | 25 ++
 rtl/cdc_fifo_rd_ctrl_sync.sv | 26 ++
 rtl/cdc_fifo_rd_ctrl.sv | 93 +++++++++
 tb/tb_cdc_fifo_rd_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_fifo_rd_ctrl_pkg.sv
// Shared helpers for the CDC FIFO read controller: Gray conversion and pointer width.
package cdc_fifo_rd_ctrl_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    // Operands are zero-extended to GRAY_MAX_W, so any narrower width converts correctly.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/cdc_fifo_rd_ctrl_sync.sv
// Two-flop synchroniser for a Gray-coded bus entering the local clock domain.
module cdc_sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* syn_preserve = 1 *) logic [WIDTH-1:0] meta;
    (* syn_preserve = 1 *) logic [WIDTH-1:0] sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/cdc_fifo_rd_ctrl.sv
// Read-domain controller of the LVDS receive CDC FIFO: pointer sync, RAM read issue,
// Gray read pointer back to the writer, and a two-entry first-word-fall-through buffer.
module cdc_fifo_rd_ctrl
    import cdc_fifo_rd_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  rdclock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH:0]   wrptr_gray,
    output logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH:0]   rdptr_gray,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_level
);

    localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);
    localparam int unsigned GW    = GRAY_MAX_W;

    logic [PTR_W-1:0]      wrptr_sync;
    logic [PTR_W-1:0]      wr_bin;
    logic [PTR_W-1:0]      rdptr;
    logic [PTR_W-1:0]      rdptr_next;
    logic [1:0]            obuf_cnt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] obuf1;
    logic                  pop_c;
    logic                  issue_c;

    cdc_sync_2ff #(.WIDTH(PTR_W)) u_wrptr_sync (
        .clock   (rdclock),
        .reset_n (reset_n),
        .d       (wrptr_gray),
        .q       (wrptr_sync)
    );

    assign wr_bin     = PTR_W'(gray2bin(GW'(wrptr_sync)));
    assign empty      = (wr_bin == rdptr);
    assign rd_level   = wr_bin - rdptr;
    assign rdaddress  = rdptr[ADDR_WIDTH-1:0];
    assign dout_valid = (obuf_cnt != 2'd0);
    assign pop_c      = dout_valid & dout_ready;

    // Occupancy counts the slot freed by a same-edge pop, keeping one word per cycle.
    assign issue_c    = !empty && ((3'(obuf_cnt) + 3'(inflight)) < (3'd2 + 3'(pop_c)));
    assign rdptr_next = rdptr + PTR_W'(issue_c);

    // dout is the buffer head; obuf1 is the skid entry behind it.
    always_ff @(posedge rdclock or negedge reset_n) begin
        if (!reset_n) begin
            rdptr      <= '0;
            rdptr_gray <= '0;
            inflight   <= 1'b0;
            obuf_cnt   <= 2'd0;
            dout       <= '0;
            obuf1      <= '0;
        end else begin
            rdptr      <= rdptr_next;
            rdptr_gray <= PTR_W'(bin2gray(GW'(rdptr_next)));
            inflight   <= issue_c;
            case ({inflight, pop_c})
                2'b11: begin
                    if (obuf_cnt == 2'd2) begin
                        dout  <= obuf1;
                        obuf1 <= ram_q;
                    end else begin
                        dout <= ram_q;
                    end
                end
                2'b10: begin
                    if (obuf_cnt == 2'd0) begin
                        dout <= ram_q;
                    end else begin
                        obuf1 <= ram_q;
                    end
                    obuf_cnt <= obuf_cnt + 2'd1;
                end
                2'b01: begin
                    dout     <= obuf1;
                    obuf_cnt <= obuf_cnt - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_fifo_rd_ctrl.sv
// Self-checking bench for cdc_fifo_rd_ctrl: RAM and write-domain models, scoreboard and per-cycle invariants.
`timescale 1ns/1ps
module tb_cdc_fifo_rd_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = AW + 1;

    logic          rdclock    = 1'b0;
    logic          wrclock    = 1'b0;
    logic          reset_n    = 1'b0;
    logic [PW-1:0] wrptr_gray = '0;
    logic [AW-1:0] rdaddress;
    logic [DW-1:0] ram_q      = '0;
    logic [PW-1:0] rdptr_gray;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          empty;
    logic [PW-1:0] rd_level;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] exp_q [$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            wr_cnt  = 0;
    int            pop_cnt = 0;
    bit            saw_addr_wrap = 0;
    bit            saw_gray_wrap = 0;
    bit            writer_done   = 0;
    logic [PW-1:0] prev_gray = '0;
    logic [AW-1:0] prev_addr = '0;
    logic [PW-1:0] issued;
    logic [PW-1:0] held;
    logic [PW-1:0] bp_start;

    cdc_fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .rdclock    (rdclock),
        .reset_n    (reset_n),
        .wrptr_gray (wrptr_gray),
        .rdaddress  (rdaddress),
        .ram_q      (ram_q),
        .rdptr_gray (rdptr_gray),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .empty      (empty),
        .rd_level   (rd_level)
    );

    always #5 rdclock = ~rdclock;
    initial begin
        #2;
        forever #7 wrclock = ~wrclock;
    end

    // Dual-clock RAM read port: registered address, data one edge later.
    always @(posedge rdclock) ram_q <= mem[rdaddress];

    function automatic logic [PW-1:0] g_of(input int n);
        logic [PW-1:0] b;
        b = PW'(n);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] b_of(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = '0;
        for (int s = 0; s < int'(PW); s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-domain model: RAM word committed before the Gray pointer advances.
    task automatic write_word(input logic [DW-1:0] d);
        mem[wr_cnt % 16] = d;
        exp_q.push_back(d);
        wr_cnt++;
        wrptr_gray = g_of(wr_cnt);
    endtask

    task automatic send_words(input int n, input logic [DW-1:0] base);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            while ((wr_cnt - pop_cnt >= 16) && guard < 500) begin
                @(posedge rdclock); #1;
                guard++;
            end
            chk("room_wait", guard < 500, 1);
            write_word(base + DW'(i));
            @(posedge rdclock); #1;
        end
    endtask

    task automatic drain(input int limit);
        int c;
        c = 0;
        dout_ready = 1'b1;
        while (exp_q.size() != 0 && c < limit) begin
            @(posedge rdclock); #1;
            c++;
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    task automatic do_reset(input bit check_now);
        @(posedge rdclock); #1;
        reset_n    = 1'b0;
        wrptr_gray = '0;
        wr_cnt     = 0;
        pop_cnt    = 0;
        exp_q.delete();
        dout_ready = 1'b0;
        if (check_now) begin
            #1;
            chk("rst_dout", dout, 0);
            chk("rst_valid", dout_valid, 0);
            chk("rst_empty", empty, 1);
            chk("rst_level", rd_level, 0);
            chk("rst_addr", rdaddress, 0);
            chk("rst_gray", rdptr_gray, 0);
        end
        repeat (2) @(posedge rdclock);
        #1 reset_n = 1'b1;
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge rdclock);
            chk("idle_empty", empty, 1);
            chk("idle_valid", dout_valid, 0);
        end
    endtask

    // Per-cycle compare: scoreboard order on every pop plus occupancy/pointer invariants.
    always @(negedge rdclock) begin
        if (!reset_n) begin
            prev_gray = '0;
            prev_addr = '0;
        end else begin
            issued = b_of(rdptr_gray);
            held   = issued - PW'(pop_cnt);
            chk("level_bound", rd_level <= 16, 1);
            chk("empty_vs_level", empty, rd_level == 0);
            chk("level_vs_written", rd_level <= PW'(PW'(wr_cnt) - issued), 1);
            chk("held_count", (held <= 2) && (held >= PW'(dout_valid)), 1);
            chk("rdaddress", rdaddress, issued[AW-1:0]);
            if (rdptr_gray != prev_gray)
                chk("gray_step", ($countones(rdptr_gray ^ prev_gray) == 1) &&
                                 (issued == PW'(b_of(prev_gray) + 1)), 1);
            if (prev_addr == 4'd15 && rdaddress == 4'd0) saw_addr_wrap = 1;
            if (prev_gray == g_of(31) && rdptr_gray == '0) saw_gray_wrap = 1;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
                else chk("dout_order", dout, exp_q.pop_front());
                pop_cnt++;
            end
            prev_gray = rdptr_gray;
            prev_addr = rdaddress;
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        chk("model_g16", g_of(16), 5'h18);
        chk("model_g31", g_of(31), 5'h10);
        chk("model_b18", b_of(5'h18), 16);

        // Reset and idle
        repeat (3) @(posedge rdclock);
        #1;
        chk("init_valid", dout_valid, 0);
        chk("init_empty", empty, 1);
        chk("init_level", rd_level, 0);
        chk("init_gray", rdptr_gray, 0);
        @(posedge rdclock); #1 reset_n = 1'b1;
        idle_check(20);

        // Single word: latency edge by edge
        @(posedge rdclock); #1;
        write_word(32'hDEAD_BEEF);
        @(posedge rdclock); @(negedge rdclock);
        chk("e0_empty", empty, 1);
        @(posedge rdclock); @(negedge rdclock);
        chk("e1_empty", empty, 0);
        chk("e1_level", rd_level, 1);
        @(posedge rdclock); @(negedge rdclock);
        chk("e2_valid", dout_valid, 0);
        chk("e2_gray", rdptr_gray, 1);
        chk("e2_empty", empty, 1);
        @(posedge rdclock); @(negedge rdclock);
        chk("e3_valid", dout_valid, 1);
        chk("e3_dout", dout, 32'hDEAD_BEEF);
        @(posedge rdclock); #1 dout_ready = 1'b1;
        @(posedge rdclock); @(negedge rdclock);
        chk("pop1_valid", dout_valid, 0);
        chk("pop1_empty", empty, 1);
        chk("pop1_gray", rdptr_gray, 1);
        chk("pop1_count", pop_cnt, 1);

        // Streaming: 16 words loaded at once
        do_reset(0);
        @(posedge rdclock); #1;
        for (int i = 0; i < 16; i++) begin
            mem[i] = DW'(i);
            exp_q.push_back(DW'(i));
        end
        wr_cnt     = 16;
        wrptr_gray = g_of(16);
        dout_ready = 1'b1;
        @(posedge rdclock);
        for (int k = 0; k <= 17; k++) begin
            @(posedge rdclock); @(negedge rdclock);
            if (k <= 16) chk("stream_level", rd_level, 16 - k);
            if (k >= 2) begin
                chk("stream_valid", dout_valid, 1);
                chk("stream_dout", dout, k - 2);
            end
        end
        @(posedge rdclock); @(negedge rdclock);
        chk("stream_end_valid", dout_valid, 0);
        chk("stream_end_gray", rdptr_gray, 5'h18);
        chk("stream_end_empty", empty, 1);

        // Back-pressure: 8 words pending with dout_ready low
        @(posedge rdclock); #1;
        dout_ready = 1'b0;
        bp_start   = b_of(rdptr_gray);
        send_words(8, 32'h100);
        for (int i = 0; i < 10; i++) begin
            @(negedge rdclock);
            chk("bp_advance", PW'(b_of(rdptr_gray) - bp_start), 2);
            chk("bp_valid", dout_valid, 1);
        end
        chk("bp_level", rd_level, 6);
        chk("bp_head", dout, 32'h100);
        @(posedge rdclock); #1;
        drain(100);
        chk("bp_pops", pop_cnt, 24);

        // Wrap: 40 words through the depth-16 FIFO
        do_reset(0);
        saw_addr_wrap = 0;
        saw_gray_wrap = 0;
        dout_ready    = 1'b1;
        send_words(40, 32'h1000);
        drain(100);
        repeat (2) @(posedge rdclock);
        chk("wrap_addr", saw_addr_wrap, 1);
        chk("wrap_gray", saw_gray_wrap, 1);
        chk("wrap_final_gray", rdptr_gray, g_of(40));
        chk("wrap_pops", pop_cnt, 40);

        // Reset mid-stream discards everything, then stays idle
        do_reset(0);
        dout_ready = 1'b1;
        send_words(6, 32'h2000);
        dout_ready = 1'b0;
        send_words(3, 32'h2100);
        do_reset(1);
        idle_check(20);

        // Asynchronous writer at 7:5 clock ratio with random back-pressure
        writer_done = 0;
        fork
            begin : writer
                int guard;
                for (int i = 0; i < 60; i++) begin
                    guard = 0;
                    @(posedge wrclock);
                    while (($urandom_range(0, 2) == 0 || wr_cnt - pop_cnt >= 16) && guard < 500) begin
                        @(posedge wrclock);
                        guard++;
                    end
                    chk("async_room", guard < 500, 1);
                    write_word(32'h5000 + DW'(i));
                end
                writer_done = 1;
            end
            begin : consumer
                int c;
                c = 0;
                while (!writer_done && c < 5000) begin
                    @(posedge rdclock); #1;
                    dout_ready = ($urandom_range(0, 3) != 0);
                    c++;
                end
            end
        join
        @(posedge rdclock); #1;
        drain(200);
        repeat (4) @(posedge rdclock);
        chk("async_pops", pop_cnt, 60);
        chk("async_empty", empty, 1);
        chk("async_gray", rdptr_gray, g_of(60));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
